// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx transmitter.
// A producer pushes bytes with wr_en/wr_data. A small drain FSM presents them one at a time
// to uart_tx through tx_send/tx_data, using tx_ready as the handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_data, wr_en    enqueue one byte per cycle while wr_en is high
//   clr_ovf           clears the sticky overflow flag
//   full, empty       fill status derived from the registered count
//   count             fill level, 0..2**ADDR_W
//   overflow          sticky: a write arrived while full and was dropped
//   tx_ready          uart_tx ready (high = idle)
//   tx_send, tx_data  send request and byte presented to uart_tx
module uart_tx_fifo #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StSend, StBusy} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              tx_send_q, tx_send_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              wr_accept;
  logic              pop;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en && !full;

  // Drain FSM. The head byte is only popped once uart_tx has taken it (tx_ready falls), so
  // an unacknowledged byte still counts toward full.
  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && tx_ready) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          pop       = 1'b1;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (tx_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        tx_send_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop wins over a coincident clear so the event is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage is not reset; only the pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;

endmodule
